// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the memory.
// Valid/ready contract: requests are levels held until the matching done pulse; m_rd/m_wr are one-cycle commands.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_rd;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          if_done;
    logic          dm_done;
    logic [DW-1:0] rdata;
    logic          if_stall;
    logic          dm_stall;
    logic          err;

    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, m_rdata,
        output m_rd, m_wr, m_addr, m_wdata, if_done, dm_done, rdata,
               if_stall, dm_stall, err
    );

    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, m_rdata,
        input  m_rd, m_wr, m_addr, m_wdata, if_done, dm_done, rdata,
               if_stall, dm_stall, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (memory stage over fetch) arbiter for a single-ported,
// fixed-latency memory; one registered command per transaction.
module mem_arbiter #(
    parameter int LAT = 4,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic       clk,
    input  logic       rst,
    mem_arbiter_if.slave bus,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_DM = 3'd1,
        BUSY_IF = 3'd2,
        ERR_DM  = 3'd3,
        ERR_IF  = 3'd4
    } state_t;

    localparam logic [4:0] DONE_CNT = 5'(LAT + 1);

    state_t     state;
    logic [4:0] cnt;
    logic       is_wr;
    logic       busy_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_wr       <= 1'b0;
            bus.m_rd    <= 1'b0;
            bus.m_wr    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
        end else begin
            bus.m_rd <= 1'b0;
            bus.m_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.dm_rd || bus.dm_wr) begin
                        // Misaligned addresses never reach the memory.
                        if (bus.dm_addr[0]) begin
                            state <= ERR_DM;
                        end else begin
                            state       <= BUSY_DM;
                            cnt         <= 5'd1;
                            is_wr       <= bus.dm_wr;
                            bus.m_wr    <= bus.dm_wr;
                            bus.m_rd    <= ~bus.dm_wr;
                            bus.m_addr  <= bus.dm_addr;
                            bus.m_wdata <= bus.dm_wr ? bus.dm_wdata : '0;
                        end
                    end else if (bus.if_req) begin
                        if (bus.if_addr[0]) begin
                            state <= ERR_IF;
                        end else begin
                            state       <= BUSY_IF;
                            cnt         <= 5'd1;
                            is_wr       <= 1'b0;
                            bus.m_rd    <= 1'b1;
                            bus.m_addr  <= bus.if_addr;
                            bus.m_wdata <= '0;
                        end
                    end
                end
                BUSY_DM, BUSY_IF: begin
                    if (cnt == DONE_CNT) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ERR_DM, ERR_IF: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

    assign busy_done    = ((state == BUSY_DM) || (state == BUSY_IF)) && (cnt == DONE_CNT);
    assign bus.if_done  = ((state == BUSY_IF) && (cnt == DONE_CNT)) || (state == ERR_IF);
    assign bus.dm_done  = ((state == BUSY_DM) && (cnt == DONE_CNT)) || (state == ERR_DM);
    assign bus.rdata    = (busy_done && !is_wr) ? bus.m_rdata : '0;
    assign bus.err      = (state == ERR_DM) || (state == ERR_IF);
    assign bus.if_stall = bus.if_req & ~bus.if_done;
    assign bus.dm_stall = (bus.dm_rd | bus.dm_wr) & ~bus.dm_done;
    assign dbg_state    = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=4 instance for arbitration, errors and
// reset abort, and a LAT=1 instance for back-to-back fetch throughput.
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_a;
    logic [2:0] dbg_b;
    int         total = 0;
    int         bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    // clock / reset
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(16)) bus_a ();
    mem_arbiter_if #(.AW(16), .DW(16)) bus_b ();

    mem_arbiter #(.LAT(4), .AW(16), .DW(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a)
    );
    mem_arbiter #(.LAT(1), .AW(16), .DW(16)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic idle_inputs();
        bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.dm_rd = 1'b0; bus_a.dm_wr = 1'b0;
        bus_a.dm_addr = '0; bus_a.dm_wdata = '0; bus_a.m_rdata = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.dm_rd = 1'b0; bus_b.dm_wr = 1'b0;
        bus_b.dm_addr = '0; bus_b.dm_wdata = '0; bus_b.m_rdata = '0;
    endtask

    task automatic fetch_a(input logic [15:0] addr, input logic [15:0] mdata);
        bus_a.if_req = 1'b1; bus_a.if_addr = addr; bus_a.m_rdata = mdata;
    endtask

    task automatic dm_a(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata);
        bus_a.dm_rd = rd; bus_a.dm_wr = wr; bus_a.dm_addr = addr; bus_a.dm_wdata = wdata;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) next_cycle();
        #1;
        check("rst_m_rd", bus_a.m_rd, 0);
        check("rst_m_wr", bus_a.m_wr, 0);
        check("rst_m_addr", bus_a.m_addr, 0);
        check("rst_m_wdata", bus_a.m_wdata, 0);
        check("rst_done", {bus_a.if_done, bus_a.dm_done}, 0);
        check("rst_rdata", bus_a.rdata, 0);
        check("rst_err", bus_a.err, 0);
        check("rst_state", dbg_a, 0);
        check("rst_state_b", dbg_b, 0);
        rst = 1'b0;
        next_cycle();

        // single fetch read, LAT=4
        next_cycle();
        fetch_a(16'h0010, 16'hBEEF);
        exp_q.push_back(16'hBEEF);
        #1;
        check("t1_stall_c0", bus_a.if_stall, 1);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            #1;
            check($sformatf("t1_m_rd_c%0d", k), bus_a.m_rd, (k == 1));
            check($sformatf("t1_done_c%0d", k), bus_a.if_done, (k == 5));
            check($sformatf("t1_stall_c%0d", k), bus_a.if_stall, (k < 5));
            if (k == 1) check("t1_m_addr", bus_a.m_addr, 16'h0010);
            if (k == 5) begin
                exp_v = exp_q.pop_front();
                check("t1_rdata", bus_a.rdata, exp_v);
                bus_a.if_req = 1'b0;
            end else begin
                check($sformatf("t1_rdata0_c%0d", k), bus_a.rdata, 0);
            end
        end
        check("t1_idle", dbg_a, 0);

        // dm write beats a simultaneous fetch
        next_cycle();
        dm_a(1'b0, 1'b1, 16'h0100, 16'h1234);
        fetch_a(16'h0010, 16'h5A5A);
        exp_q.push_back(16'h5A5A);
        for (int k = 1; k <= 11; k++) begin
            next_cycle();
            #1;
            check($sformatf("t2_m_wr_c%0d", k), bus_a.m_wr, (k == 1));
            check($sformatf("t2_m_rd_c%0d", k), bus_a.m_rd, (k == 7));
            check($sformatf("t2_dm_done_c%0d", k), bus_a.dm_done, (k == 5));
            check($sformatf("t2_if_done_c%0d", k), bus_a.if_done, (k == 11));
            check($sformatf("t2_if_stall_c%0d", k), bus_a.if_stall, (k < 11));
            if (k <= 5) check($sformatf("t2_dm_stall_c%0d", k), bus_a.dm_stall, (k < 5));
            if (k == 1) begin
                check("t2_wr_addr", bus_a.m_addr, 16'h0100);
                check("t2_wr_data", bus_a.m_wdata, 16'h1234);
            end
            if (k == 5) begin
                check("t2_wr_rdata", bus_a.rdata, 0);
                dm_a(1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            if (k == 7) check("t2_rd_addr", bus_a.m_addr, 16'h0010);
            if (k == 11) begin
                exp_v = exp_q.pop_front();
                check("t2_rdata", bus_a.rdata, exp_v);
                bus_a.if_req = 1'b0;
            end
        end

        // misaligned dm read
        next_cycle();
        dm_a(1'b1, 1'b0, 16'h0003, 16'h0000);
        bus_a.m_rdata = 16'hFFFF;
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            #1;
            check($sformatf("t3_done_c%0d", k), bus_a.dm_done, (k == 1));
            check($sformatf("t3_err_c%0d", k), bus_a.err, (k == 1));
            check($sformatf("t3_rdata_c%0d", k), bus_a.rdata, 0);
            check($sformatf("t3_cmd_c%0d", k), {bus_a.m_rd, bus_a.m_wr}, 0);
            if (k == 1) dm_a(1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        check("t3_idle", dbg_a, 0);

        // read and write together: write wins
        next_cycle();
        dm_a(1'b1, 1'b1, 16'h0020, 16'hA5A5);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            #1;
            check($sformatf("t4_m_wr_c%0d", k), bus_a.m_wr, (k == 1));
            check($sformatf("t4_m_rd_c%0d", k), bus_a.m_rd, 0);
            check($sformatf("t4_done_c%0d", k), bus_a.dm_done, (k == 5));
            if (k == 1) check("t4_wdata", bus_a.m_wdata, 16'hA5A5);
            if (k == 5) begin
                check("t4_rdata", bus_a.rdata, 0);
                dm_a(1'b0, 1'b0, 16'h0000, 16'h0000);
            end
        end

        // reset mid-read, then a fresh fetch
        next_cycle();
        fetch_a(16'h0040, 16'h7777);
        exp_q.push_back(16'h7777);
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            #1;
            check($sformatf("t5_m_rd_c%0d", k), bus_a.m_rd, (k == 1 || k == 5));
            check($sformatf("t5_done_c%0d", k), bus_a.if_done, (k == 9));
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                check("t5_idle", dbg_a, 0);
                rst = 1'b0;
            end
            if (k == 5) check("t5_m_addr", bus_a.m_addr, 16'h0040);
            if (k == 9) begin
                exp_v = exp_q.pop_front();
                check("t5_rdata", bus_a.rdata, exp_v);
                bus_a.if_req = 1'b0;
            end
        end

        // LAT=1 back-to-back fetches; rdata changes every cycle
        next_cycle();
        bus_b.if_req = 1'b1; bus_b.if_addr = 16'h0200; bus_b.m_rdata = 16'h1000;
        exp_q.push_back(16'h1002); exp_q.push_back(16'h1005);
        exp_q.push_back(16'h1008); exp_q.push_back(16'h100B);
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            bus_b.m_rdata = 16'h1000 + 16'(k);
            #1;
            check($sformatf("t6_done_c%0d", k), bus_b.if_done, (k <= 11 && (k % 3) == 2));
            check($sformatf("t6_m_rd_c%0d", k), bus_b.m_rd, (k <= 11 && (k % 3) == 1));
            if (k == 1) check("t6_m_addr", bus_b.m_addr, 16'h0200);
            if (bus_b.if_done && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check($sformatf("t6_rdata_c%0d", k), bus_b.rdata, exp_v);
            end
            if (k == 11) bus_b.if_req = 1'b0;
        end
        check("t6_all_done", exp_q.size(), 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-ported, fixed-latency 16-bit memory between the fetch stage and the memory stage of the pipelined processor.
- Arbitrates with fixed priority: memory stage first, then fetch.
- Issues one registered command per transaction, counts the memory latency, and returns a one-cycle done pulse with read data.
- Produces the stall signals the pipeline control uses to freeze fetch and the memory stage.

## Interface
Parameters:
- LAT, 4, memory read/write latency in cycles from command cycle to data-valid cycle (legal 1..15)
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request, level; held until if_done
- if_addr  in  AW  fetch address, stable while if_req high
- dm_rd  in  1  memory-stage read request, level
- dm_wr  in  1  memory-stage write request, level
- dm_addr  in  AW  memory-stage address, stable while request high
- dm_wdata  in  DW  write data, stable while dm_wr high
- m_rdata  in  DW  memory read data, valid LAT cycles after the read command cycle
- m_rd  out  1  memory read command, one-cycle pulse
- m_wr  out  1  memory write command, one-cycle pulse
- m_addr  out  AW  registered command address
- m_wdata  out  DW  registered write data
- if_done  out  1  fetch transaction complete, one-cycle pulse
- dm_done  out  1  memory-stage transaction complete, one-cycle pulse
- rdata  out  DW  read data, valid only in a done cycle; 0 otherwise
- if_stall  out  1  if_req & ~if_done
- dm_stall  out  1  (dm_rd | dm_wr) & ~dm_done
- err  out  1  alignment error, valid with the done pulse

## Operation
States:
- IDLE: no transaction in flight.
- BUSY_DM: serving a memory-stage transaction.
- BUSY_IF: serving a fetch transaction.
- ERR_DM, ERR_IF: one-cycle error-response states.

Transitions out of IDLE:
- If dm_rd or dm_wr is high → BUSY_DM. dm_wr takes precedence when both are high; the transaction is a write.
- Else if if_req is high → BUSY_IF.
- Before issuing, the selected address is checked: if bit 0 is 1, go to ERR_DM or ERR_IF instead of BUSY. No memory command is issued in that case.

Command capture:
- The edge entering BUSY_x registers m_addr, m_wdata and the command type.
- The latency counter loads 1.

BUSY_x behaviour:
- m_rd or m_wr is high only in the first BUSY cycle.
- The counter increments every BUSY cycle.
- When counter == LAT+1: assert the matching done, drive rdata = m_rdata (reads) or 0 (writes), and return to IDLE on the next edge.

ERR_x behaviour:
- Assert the matching done with err = 1 and rdata = 0, then return to IDLE.

Requester rules:
- A request still high in the IDLE cycle after done is treated as a new transaction.
- A request dropped mid-transaction does not abort it; done still pulses.
- A request arriving while the other requester is being served waits, with its stall held high.

Reset:
- rst high at any edge forces IDLE and counter 0.
- An in-flight transaction is abandoned with no done pulse; the late m_rdata is ignored.

## Timing
- Reset values: m_rd = m_wr = 0, m_addr = m_wdata = 0, if_done = dm_done = 0, rdata = 0, err = 0, state IDLE.
- Cycle numbering: request high in IDLE at cycle 0.
- Cycle 1: command cycle (m_rd or m_wr high).
- Cycle LAT+1: m_rdata valid; done pulses.
- Cycle LAT+2: earliest command cycle of the next transaction is LAT+3 (IDLE at LAT+2).
- Sustained throughput: one transaction per LAT+2 cycles.
- Misaligned access: done plus err at cycle 1, with no memory command.
- Simultaneous dm and if requests in IDLE: dm is served first. if is served in the IDLE cycle after dm completes, provided no new dm request is present.
- Fetch starvation under back-to-back dm requests is accepted, because dm_stall freezes the pipeline.
- done, rdata and err are combinational from state and counter; no output depends combinationally on any *_req input except the stall signals.

## Test plan
- LAT=4; if_req=1, if_addr=0x0010; memory returns 0xBEEF at cycle 5 → m_rd at cycle 1 with m_addr=0x0010; if_done and rdata=0xBEEF at cycle 5; if_stall high in cycles 0-4.
- dm_wr=1, dm_addr=0x0100, dm_wdata=0x1234, alongside if_req=1 at cycle 0 → m_wr at cycle 1 with 0x0100/0x1234; dm_done at cycle 5 with rdata=0; m_rd for fetch at cycle 7; if_done at cycle 11.
- dm_rd=1 with dm_addr=0x0003 → dm_done and err at cycle 1; m_rd and m_wr never asserted.
- dm_rd and dm_wr both high, addr 0x0020 → m_wr issued, not m_rd; dm_done at cycle 5.
- rst asserted at cycle 3 of a read → IDLE at cycle 4; no done pulse; a new if_req at cycle 4 gives a command at cycle 5.
- LAT=1, four back-to-back fetch reads → done at cycles 2, 5, 8, 11.
